ct_spsram_256x7_ctrl: RTL and testbench

Sequencer and arbiter in front of one 256x7 single-port SRAM (active-low CEN/GWEN/per-bit WEN, 1-cycle read latency). Shares the SRAM between one read requester and one masked-write requester using a two-way round-robin, and clears the array after reset and on demand. Sits between the pipeline tag/state logic and the SRAM macro wrapper.

---
 rtl/ct_spsram_ctrl_pkg.sv | 21 ++
 rtl/ct_spsram_256x7_ctrl_if.sv | 49 ++++
 rtl/ct_spsram_rr_arb2.sv | 31 +++
 rtl/ct_spsram_256x7_ctrl.sv | 145 ++++++++++++++
 tb/tb_ct_spsram_256x7_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ct_spsram_ctrl_pkg.sv
// Shared constants for the 256x7 single-port SRAM controller:
// FSM state encodings, round-robin pointer encodings and default geometry.
package ct_spsram_ctrl_pkg;

  typedef logic [1:0] ct_state_t;

  // Controller FSM states
  localparam ct_state_t ST_IDLE = 2'd0;
  localparam ct_state_t ST_INIT = 2'd1;
  localparam ct_state_t ST_RUN  = 2'd2;

  // Round-robin pointer: records which side won the last contested cycle
  localparam logic RR_RD = 1'b0;
  localparam logic RR_WR = 1'b1;

  // Default geometry and clear value
  localparam int         CT_AW       = 8;
  localparam int         CT_DW       = 7;
  localparam logic [6:0] CT_INIT_VAL = 7'h00;

endpackage

// File: rtl/ct_spsram_256x7_ctrl_if.sv
// Bus bundle between requesters, the SRAM controller and the SRAM macro.
//
// Handshake: a requester raises *_req with its address/data stable and holds
// them until it sees *_gnt high in the same cycle; the transfer happens on
// the rising edge where req & gnt are both 1. Grants are combinational and
// nothing is queued inside the controller. Read data returns on rd_vld one
// cycle after rd_gnt, with no back-pressure.
interface ct_spsram_256x7_ctrl_if #(
  parameter int AW = 8,
  parameter int DW = 7
);
  // read requester
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_gnt;
  logic          rd_vld;
  logic [DW-1:0] rd_data;
  // masked-write requester
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] wr_mask;
  logic          wr_gnt;
  // clear control
  logic          init_start;
  logic          init_busy;
  // SRAM macro pins
  logic [AW-1:0] sram_a;
  logic          sram_cen;
  logic          sram_gwen;
  logic [DW-1:0] sram_wen;
  logic [DW-1:0] sram_d;
  logic [DW-1:0] sram_q;
  // FSM state for observation
  logic [1:0]    dbg_state;

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_mask, init_start, sram_q,
    output rd_gnt, rd_vld, rd_data, wr_gnt, init_busy,
           sram_a, sram_cen, sram_gwen, sram_wen, sram_d, dbg_state
  );

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_mask, init_start, sram_q,
    input  rd_gnt, rd_vld, rd_data, wr_gnt, init_busy,
           sram_a, sram_cen, sram_gwen, sram_wen, sram_d, dbg_state
  );

endinterface

// File: rtl/ct_spsram_rr_arb2.sv
// Two-requester round-robin arbiter. req[0]/gnt[0] is the read side,
// req[1]/gnt[1] the write side. The pointer only moves on contested cycles,
// so a lone requester never changes who wins the next tie.
module ct_spsram_rr_arb2
  import ct_spsram_ctrl_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  logic r_last;
  logic w_rd_gnt;
  logic w_wr_gnt;

  assign w_rd_gnt = i_en & i_req[0] & (~i_req[1] | (r_last == RR_WR));
  assign w_wr_gnt = i_en & i_req[1] & ~w_rd_gnt;
  assign o_gnt    = {w_wr_gnt, w_rd_gnt};

  // Remember the winner of a contested cycle; read wins the first tie
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_last <= RR_WR;
    end else if (i_en & i_req[0] & i_req[1]) begin
      r_last <= w_rd_gnt ? RR_RD : RR_WR;
    end
  end

endmodule

// File: rtl/ct_spsram_256x7_ctrl.sv
// Sequencer/arbiter in front of a 256x7 single-port SRAM (active-low
// CEN/GWEN/WEN, 1-cycle read latency). Arbitrates one reader and one masked
// writer round-robin and optionally clears the array after reset/on demand.
// Build option: CT_SPSRAM_CTRL_INIT_EN enables the clear sweep (INIT state,
// init_start, init_busy). Without it the FSM goes IDLE->RUN directly.
module ct_spsram_256x7_ctrl
  import ct_spsram_ctrl_pkg::*;
#(
  parameter int            AW       = CT_AW,
  parameter int            DW       = CT_DW,
  parameter logic [DW-1:0] INIT_VAL = DW'(CT_INIT_VAL)
) (
  input  logic                   CLK,
  input  logic                   RST,
  ct_spsram_256x7_ctrl_if.slave  bus
);

  logic [1:0]    r_state;
  logic [1:0]    w_next;
  logic [1:0]    w_gnt;
  logic          r_rd_vld;
  logic [AW-1:0] r_a;
  logic [DW-1:0] r_d;
  logic [AW-1:0] w_a;
  logic [DW-1:0] w_d;
  logic          w_cen;
  logic          w_gwen;
  logic [DW-1:0] w_wen;
  logic          w_init_go;
  logic          w_init_last;
  logic [AW-1:0] w_init_a;

`ifdef CT_SPSRAM_CTRL_INIT_EN
  localparam logic [1:0] ST_AFTER_RST = ST_INIT;
  logic [AW-1:0] r_init_cnt;

  assign w_init_go     = bus.init_start;
  assign w_init_last   = (r_init_cnt == {AW{1'b1}});
  assign w_init_a      = r_init_cnt;
  assign bus.init_busy = (r_state == ST_INIT);

  // Sweep address: steps once per INIT cycle and wraps to 0 after the last entry
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_init_cnt <= '0;
    end else if (r_state == ST_INIT) begin
      r_init_cnt <= r_init_cnt + 1'b1;
    end
  end
`else
  localparam logic [1:0] ST_AFTER_RST = ST_RUN;
  logic w_unused_init_start;

  assign w_unused_init_start = bus.init_start;
  assign w_init_go           = 1'b0;
  assign w_init_last         = 1'b1;
  assign w_init_a            = '0;
  assign bus.init_busy       = 1'b0;
`endif

  ct_spsram_rr_arb2 u_arb (
    .i_clk (CLK),
    .i_rst (RST),
    .i_en  (r_state == ST_RUN),
    .i_req ({bus.wr_req, bus.rd_req}),
    .o_gnt (w_gnt)
  );

  assign bus.rd_gnt = w_gnt[0];
  assign bus.wr_gnt = w_gnt[1];

  // Next-state: leave IDLE right after reset, finish sweep on last entry
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: w_next = ST_AFTER_RST;
      ST_INIT: if (w_init_last) w_next = ST_RUN;
      ST_RUN:  if (w_init_go)   w_next = ST_INIT;
      default: w_next = ST_IDLE;
    endcase
  end

  // SRAM pin drive; address/data hold their last value when nothing is granted
  always_comb begin
    w_cen  = 1'b1;
    w_gwen = 1'b1;
    w_wen  = '1;
    w_a    = r_a;
    w_d    = r_d;
    case (r_state)
      ST_IDLE: begin
        w_a = '0;
        w_d = '0;
      end
      ST_INIT: begin
        w_cen  = 1'b0;
        w_gwen = 1'b0;
        w_wen  = '0;
        w_a    = w_init_a;
        w_d    = INIT_VAL;
      end
      ST_RUN: begin
        if (w_gnt[0]) begin
          w_cen = 1'b0;
          w_a   = bus.rd_addr;
        end else if (w_gnt[1]) begin
          w_cen  = 1'b0;
          w_gwen = 1'b0;
          w_wen  = ~bus.wr_mask;
          w_a    = bus.wr_addr;
          w_d    = bus.wr_data;
        end
      end
      default: begin
        w_a = '0;
        w_d = '0;
      end
    endcase
  end

  // State, held pin values and read-valid pipeline stage
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= ST_IDLE;
      r_a      <= '0;
      r_d      <= '0;
      r_rd_vld <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_a      <= w_a;
      r_d      <= w_d;
      r_rd_vld <= w_gnt[0];
    end
  end

  assign bus.sram_cen  = w_cen;
  assign bus.sram_gwen = w_gwen;
  assign bus.sram_wen  = w_wen;
  assign bus.sram_a    = w_a;
  assign bus.sram_d    = w_d;
  assign bus.rd_vld    = r_rd_vld;
  assign bus.rd_data   = r_rd_vld ? bus.sram_q : '0;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_ct_spsram_256x7_ctrl.sv
// Bench for ct_spsram_256x7_ctrl with a behavioural 256x7 SRAM and a
// read-data scoreboard. Covers both builds of CT_SPSRAM_CTRL_INIT_EN.
module tb_ct_spsram_256x7_ctrl;

  localparam int AW = 8;
  localparam int DW = 7;

  logic CLK;
  logic RST;

  ct_spsram_256x7_ctrl_if #(.AW(AW), .DW(DW)) bus ();

  ct_spsram_256x7_ctrl #(.AW(AW), .DW(DW), .INIT_VAL(7'h00)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  // ---------------- SRAM model ----------------
  logic [DW-1:0] sram_mem [256];
  logic [DW-1:0] sram_q_r;
  assign bus.sram_q = sram_q_r;

  always @(posedge CLK) begin
    if (!bus.sram_cen) begin
      if (!bus.sram_gwen) begin
        for (int b = 0; b < DW; b++)
          if (!bus.sram_wen[b]) sram_mem[bus.sram_a][b] <= bus.sram_d[b];
      end else begin
        sram_q_r <= sram_mem[bus.sram_a];
      end
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] last_rd;
  logic          vld_in_init;

  always @(negedge CLK) begin
    if (!RST) begin
      logic [DW-1:0] e;
      check("gnt_excl", {31'd0, bus.rd_gnt & bus.wr_gnt}, 32'd0);
      if (bus.rd_vld) begin
        if (bus.init_busy) vld_in_init = 1'b1;
        if (exp_q.size() == 0) begin
          check("rd_vld_unexpected", 32'd1, 32'd0);
        end else begin
          e       = exp_q.pop_front();
          last_rd = bus.rd_data;
          if (!$isunknown(e)) check("rd_data", {25'd0, bus.rd_data}, {25'd0, e});
        end
      end else begin
        check("rd_data_idle", {25'd0, bus.rd_data}, 32'd0);
      end
      if (bus.rd_gnt) exp_q.push_back(ref_mem[bus.rd_addr]);
      if (bus.wr_gnt)
        ref_mem[bus.wr_addr] = (ref_mem[bus.wr_addr] & ~bus.wr_mask) | (bus.wr_data & bus.wr_mask);
    end
  end

  // ---------------- driver tasks (enter and leave at posedge+1) ----------------
  logic [DW-1:0] last_wen;

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] m);
    int n = 0;
    bus.wr_req = 1'b1; bus.wr_addr = a; bus.wr_data = d; bus.wr_mask = m;
    do begin
      @(negedge CLK);
      n++;
    end while (!bus.wr_gnt && n < 20);
    if (!bus.wr_gnt) check("wr_timeout", 32'd0, 32'd1);
    else begin
      last_wen = bus.sram_wen;
      check("wr_pins", {8'd0, bus.sram_cen, bus.sram_gwen, bus.sram_wen, bus.sram_a, bus.sram_d},
            {8'd0, 1'b0, 1'b0, ~m, a, d});
    end
    @(posedge CLK); #1;
    bus.wr_req = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    int n = 0;
    bus.rd_req = 1'b1; bus.rd_addr = a;
    do begin
      @(negedge CLK);
      n++;
    end while (!bus.rd_gnt && n < 20);
    if (!bus.rd_gnt) check("rd_timeout", 32'd0, 32'd1);
    else check("rd_pins", {15'd0, bus.sram_cen, bus.sram_gwen, bus.sram_wen, bus.sram_a},
               {15'd0, 1'b0, 1'b1, 7'h7F, a});
    @(posedge CLK); #1;
    bus.rd_req = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 10) begin
      @(negedge CLK);
      n++;
    end
    check("drain", exp_q.size(), 32'd0);
    @(posedge CLK); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check(tag, {2'd0, bus.sram_cen, bus.sram_gwen, bus.sram_wen, bus.sram_a, bus.sram_d,
                bus.rd_vld, bus.init_busy, bus.rd_gnt, bus.wr_gnt, bus.dbg_state},
          {2'd0, 1'b1, 1'b1, 7'h7F, 8'h00, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0});
  endtask

`ifdef CT_SPSRAM_CTRL_INIT_EN
  // Follow a clear sweep; returns at the negedge of the first RUN cycle or
  // once stop_at entries have been observed.
  task automatic sweep_check(input int stop_at, output int cnt);
    int waited = 0;
    cnt = 0;
    forever begin
      @(negedge CLK);
      if (bus.init_busy) begin
        check("sweep_pins", {8'd0, bus.sram_cen, bus.sram_gwen, bus.sram_wen, bus.sram_a, bus.sram_d},
              {8'd0, 1'b0, 1'b0, 7'h00, cnt[7:0], 7'h00});
        check("sweep_gnt", {30'd0, bus.rd_gnt, bus.wr_gnt}, 32'd0);
        cnt++;
        if (cnt == stop_at) break;
      end else if (cnt > 0 || bus.dbg_state == 2'd2) begin
        break;
      end else begin
        waited++;
        if (waited > 10) begin
          check("sweep_start_timeout", 32'd0, 32'd1);
          break;
        end
      end
    end
  endtask
`endif

  // ---------------- main sequence ----------------
  initial begin
    int cnt;
    logic [AW-1:0] ra;
    logic [DW-1:0] d1, d2, rm;

    RST = 1'b1;
    bus.rd_req = 1'b1; bus.rd_addr = 8'h30;
    bus.wr_req = 1'b1; bus.wr_addr = 8'h30; bus.wr_data = 7'h55; bus.wr_mask = 7'h7F;
    bus.init_start = 1'b0;
    vld_in_init = 1'b0;
    last_rd = '0;
    last_wen = '0;
`ifdef CT_SPSRAM_CTRL_INIT_EN
    for (int i = 0; i < 256; i++) ref_mem[i] = 7'h00;
`endif

    // reset values with both requests pending
    @(negedge CLK);
    @(negedge CLK);
    check_reset_outputs("reset_outputs");
    @(posedge CLK); #1;
    RST = 1'b0;

`ifdef CT_SPSRAM_CTRL_INIT_EN
    sweep_check(1000, cnt);
    check("sweep_len", cnt, 32'd256);
`else
    cnt = 0;
    do begin
      @(negedge CLK);
      cnt++;
    end while (bus.dbg_state != 2'd2 && cnt < 10);
    check("enter_run", {30'd0, bus.dbg_state}, 32'd2);
    check("busy_tied0", {31'd0, bus.init_busy}, 32'd0);
`endif

    // contested requests alternate starting with read
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge CLK);
      check("alt_gnt", {30'd0, bus.rd_gnt, bus.wr_gnt}, (i % 2 == 0) ? 32'd2 : 32'd1);
    end
    @(posedge CLK); #1;
    bus.wr_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check("lone_rd", {30'd0, bus.rd_gnt, bus.wr_gnt}, 32'd2);
    end
    @(posedge CLK); #1;
    bus.wr_req = 1'b1;
    @(negedge CLK);
    check("tie_after_lone_0", {30'd0, bus.rd_gnt, bus.wr_gnt}, 32'd2);
    @(negedge CLK);
    check("tie_after_lone_1", {30'd0, bus.rd_gnt, bus.wr_gnt}, 32'd1);
    @(posedge CLK); #1;
    bus.rd_req = 1'b0; bus.wr_req = 1'b0;
    drain();

    // full write then read back (read the cycle after the write)
    do_write(8'h10, 7'h2A, 7'h7F);
    do_read(8'h10);
    drain();
    check("rd_2a", {25'd0, last_rd}, 32'h2A);

    // masked write of bit 0 only, then idle hold of address/data
    do_write(8'h10, 7'h7F, 7'h01);
    check("wen_masked", {25'd0, last_wen}, 32'h7E);
    do_read(8'h10);
    @(negedge CLK);
    check("hold_pins", {9'd0, bus.sram_cen, bus.sram_gwen, bus.sram_a, bus.sram_d},
          {9'd0, 1'b1, 1'b1, 8'h10, 7'h7F});
    @(posedge CLK); #1;
    drain();
    check("rd_2b", {25'd0, last_rd}, 32'h2B);

    // zero mask still takes the grant and leaves data untouched
    do_write(8'h10, 7'h00, 7'h00);
    do_read(8'h10);
    drain();
    check("rd_zero_mask", {25'd0, last_rd}, 32'h2B);

    // random full + masked writes, each read back
    for (int i = 0; i < 6; i++) begin
      ra = 8'h40 + 8'(i);
      d1 = 7'($urandom_range(0, 127));
      d2 = 7'($urandom_range(0, 127));
      rm = 7'($urandom_range(1, 127));
      do_write(ra, d1, 7'h7F);
      do_write(ra, d2, rm);
      do_read(ra);
    end
    drain();

`ifdef CT_SPSRAM_CTRL_INIT_EN
    // clear request together with a granted read
    vld_in_init = 1'b0;
    bus.rd_req = 1'b1; bus.rd_addr = 8'h10; bus.init_start = 1'b1;
    @(negedge CLK);
    check("init_rd_gnt", {31'd0, bus.rd_gnt}, 32'd1);
    @(posedge CLK); #1;
    bus.rd_req = 1'b0; bus.init_start = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 7'h00;
    sweep_check(1000, cnt);
    check("init_sweep_len", cnt, 32'd256);
    check("vld_first_init", {31'd0, vld_in_init}, 32'd1);
    check("rd_before_clear", {25'd0, last_rd}, 32'h2B);
    @(posedge CLK); #1;
    do_read(8'h10);
    do_read(8'h41);
    drain();
    check("rd_after_clear", {25'd0, last_rd}, 32'h00);

    // reset in the middle of a sweep, then the sweep restarts from 0
    bus.init_start = 1'b1;
    @(posedge CLK); #1;
    bus.init_start = 1'b0;
    sweep_check(101, cnt);
    check("mid_sweep_a", {24'd0, bus.sram_a}, 32'd100);
    #2;
    RST = 1'b1;
    #1;
    check_reset_outputs("mid_sweep_reset");
    @(posedge CLK); #1;
    RST = 1'b0;
    sweep_check(1000, cnt);
    check("restart_sweep_len", cnt, 32'd256);
    @(posedge CLK); #1;
    do_read(8'h10);
    drain();
    check("rd_after_restart", {25'd0, last_rd}, 32'h00);
`else
    // clear request is ignored without the sweep option
    bus.init_start = 1'b1;
    @(posedge CLK); #1;
    bus.init_start = 1'b0;
    @(negedge CLK);
    check("init_ignored", {29'd0, bus.init_busy, bus.dbg_state}, 32'd2);
    @(posedge CLK); #1;

    // asynchronous reset while running
    @(negedge CLK);
    #2;
    RST = 1'b1;
    #1;
    check_reset_outputs("mid_run_reset");
    @(posedge CLK); #1;
    RST = 1'b0;
    cnt = 0;
    do begin
      @(negedge CLK);
      cnt++;
    end while (bus.dbg_state != 2'd2 && cnt < 10);
    check("rerun", {30'd0, bus.dbg_state}, 32'd2);
    @(posedge CLK); #1;
    do_read(8'h10);
    drain();
    check("rd_after_reset", {25'd0, last_rd}, 32'h2B);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
